pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch front end of the pipelined MIPS core.
//  Consumes the sequential next-PC (pc+4) and redirect targets, issues word fetches to instruction memory
//  over a valid/ready request + valid response interface, and presents instr/pc/pc+4 to the IF/ID register.
//  One request outstanding max; one-entry skid buffer absorbs a response that arrives while ID is stalled.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset (word aligned)
//  ADDR_W     32             PC / memory address width
// PORTS
//  clk             in   1       single clock, all state on rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  stall           in   1       hazard unit: hold IF/ID outputs
//  redirect_valid  in   1       branch/jump taken; flush fetch
//  redirect_pc     in   ADDR_W  new fetch target
//  imem_req_valid  out  1       fetch request present
//  imem_req_ready  in   1       memory accepts request
//  imem_req_addr   out  ADDR_W  fetch address
//  imem_rsp_valid  in   1       response data valid (>=1 cycle after accept, in order)
//  imem_rsp_data   in   32      fetched instruction word
//  if_valid        out  1       if_* outputs hold a live instruction
//  if_instr        out  32      instruction to ID
//  if_pc           out  ADDR_W  address of if_instr
//  if_pc_plus4     out  ADDR_W  if_pc + 4
// BEHAVIOUR
//  Reset (async assert): state=S_REQ, pc=RESET_PC, req_addr=RESET_PC, imem_req_valid=0 while rst_n low,
//   if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, skid empty, kill=0. First request cycle after release.
//  States: S_REQ (req_valid=1), S_WAIT (one request in flight), S_HOLD (skid full, no request).
//  S_REQ: req_valid & req_addr held stable until req_ready; on accept -> S_WAIT, inflight_pc<=req_addr,
//   pc<=req_addr+4. Never retract a request.
//  S_WAIT on rsp_valid: kill=1 -> drop data, kill<=0, S_REQ at pc. Else if (!if_valid | !stall) ->
//   load if_*, if_valid=1, S_REQ; else -> load skid, S_HOLD.
//  S_HOLD: !stall -> if_* <= skid, skid empty, S_REQ. No request issued while skid full.
//  stall with if_valid=0: outputs may load (bubble is not held).
//  When not stalled and no response loads: if_valid<=0 (bubble advances).
//  Redirect (priority over stall, any state): pc<=redirect_pc, if_valid<=0, skid emptied.
//   Request in flight, or S_REQ not yet accepted -> kill<=1; that response is discarded.
//   Next req_addr = redirect_pc. Redirect same cycle as rsp_valid: response discarded, kill not set.
//  Arithmetic: pc+4 modulo 2^ADDR_W (32'hFFFF_FFFC -> 32'h0000_0000); if_pc_plus4 wraps likewise.
//  redirect_pc[1:0] ignored (forced to 2'b00). Peak throughput 1 instr / 2 cycles.
//  Reset mid-transaction: all state cleared; late responses after reset ignored (state S_REQ, none pending).
// CONFIGURATION
//  PC_FETCH_PERF_EN defined: extra outputs perf_fetch_cnt[31:0] (responses delivered to if_*) and
//   perf_kill_cnt[31:0] (responses discarded); both reset 0, wrap at 2^32.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Package mips_fetch_pkg: fetch_state_e {S_REQ,S_WAIT,S_HOLD}, RESET_PC default, INSTR_W=32, PC_STEP=4.
//  Sub-module fetch_skid_buf: one-entry {instr,pc} holding register with load/drain/flush.
//  Top: FSM, pc/req_addr/inflight_pc/kill regs, IF/ID output regs, optional counters.
// TESTING
//  Reset release, ready=1, 1-cycle latency -> req_addr 0x0,0x4,0x8; if_pc follows, if_pc_plus4=if_pc+4.
//  ready low 3 cycles in S_REQ -> req_addr/req_valid stable; accept on 4th cycle, no duplicate.
//  stall=1 with if_valid, response 0x2402_0005 arrives -> into skid, no new request; stall=0 -> if_instr
//   0x2402_0005 next cycle, then request resumes.
//  redirect_pc=0x0040_0100 while in S_WAIT -> in-flight response dropped, if_valid=0, next req 0x0040_0100.
//  redirect same cycle as stall in S_HOLD -> skid flushed, if_valid=0, req 0x0040_0100.
//  redirect to 0xFFFF_FFFC -> following req 0x0000_0000, if_pc_plus4=0x0. rst_n low mid-S_WAIT -> outputs
//   reset at once; stray rsp_valid after release ignored; first req 0x0.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_W          = 32;
    localparam int          PC_STEP          = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register that parks a fetch response while ID is stalled.
module fetch_skid_buf
    import mips_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_drain,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_full,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc
);

    logic               r_full;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;

    // Flush wins over a simultaneous load so a redirected fetch never survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_full  = r_full;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch front end; one request outstanding, one-entry skid.
// Optional performance counters enabled by defining PC_FETCH_PERF_EN.
module pc_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_kill_cnt
`endif
);

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(PC_STEP);
    endfunction

    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic               r_kill;
    logic               r_if_valid;
    logic [INSTR_W-1:0] r_if_instr;
    logic [ADDR_W-1:0]  r_if_pc;
    logic [ADDR_W-1:0]  r_if_pc_plus4;

    logic [ADDR_W-1:0]  w_redir_pc;
    logic               w_accept;
    logic               w_rsp;
    logic               w_deliver;
    logic               w_load_skid;
    logic               w_drain;
    logic               w_skid_full;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [ADDR_W-1:0]  w_skid_pc;

    assign w_redir_pc     = redirect_pc & ~ADDR_W'(3);
    assign imem_req_valid = rst_n & (r_state == S_REQ);
    assign imem_req_addr  = r_req_addr;
    assign w_accept       = imem_req_valid & imem_req_ready;
    assign w_rsp          = (r_state == S_WAIT) & imem_rsp_valid;
    assign w_deliver      = w_rsp & ~r_kill & ~redirect_valid & (~r_if_valid | ~stall);
    assign w_load_skid    = w_rsp & ~r_kill & ~redirect_valid & r_if_valid & stall;
    assign w_drain        = (r_state == S_HOLD) & w_skid_full & ~redirect_valid & ~stall;

    fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load_skid),
        .i_drain (w_drain),
        .i_flush (redirect_valid),
        .i_instr (imem_rsp_data),
        .i_pc    (r_inflight_pc),
        .o_full  (w_skid_full),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_inflight_pc <= '0;
            r_kill        <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_if_pc_plus4 <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        r_state       <= S_WAIT;
                        r_inflight_pc <= r_req_addr;
                        // A pending kill means r_pc already holds the redirect target.
                        if (!r_kill && !redirect_valid)
                            r_pc <= pc_inc(r_req_addr);
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state    <= w_load_skid ? S_HOLD : S_REQ;
                        r_req_addr <= r_pc;
                        r_kill     <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_drain)
                        r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase

            if (w_deliver) begin
                r_if_valid    <= 1'b1;
                r_if_instr    <= imem_rsp_data;
                r_if_pc       <= r_inflight_pc;
                r_if_pc_plus4 <= pc_inc(r_inflight_pc);
            end else if (w_drain) begin
                r_if_valid    <= 1'b1;
                r_if_instr    <= w_skid_instr;
                r_if_pc       <= w_skid_pc;
                r_if_pc_plus4 <= pc_inc(w_skid_pc);
            end else if (!stall) begin
                r_if_valid <= 1'b0;
            end

            // Redirect overrides stall; an unanswered request is left to complete and killed.
            if (redirect_valid) begin
                r_pc       <= w_redir_pc;
                r_if_valid <= 1'b0;
                case (r_state)
                    S_REQ:  r_kill <= 1'b1;
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            r_kill     <= 1'b0;
                            r_req_addr <= w_redir_pc;
                        end else begin
                            r_kill <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= S_REQ;
                        r_kill     <= 1'b0;
                        r_req_addr <= w_redir_pc;
                    end
                endcase
            end
        end
    end

    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;

`ifdef PC_FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_kill_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_kill_cnt  <= '0;
        end else begin
            if (w_deliver || w_drain)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if ((w_rsp && (r_kill || redirect_valid)) || (redirect_valid && w_skid_full))
                r_kill_cnt <= r_kill_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_kill_cnt  = r_kill_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table-driven bench for pc_fetch_unit: per-cycle inputs with hand-derived outputs.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    pc_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        rspv;
        logic [31:0] rdata;
        logic        qv;
        logic [31:0] qa;
        logic        iv;
        logic [31:0] ii;
        logic [31:0] ip;
        logic [31:0] ip4;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h1111_0004, A2 = 32'h1111_0008;
    localparam logic [31:0] A3 = 32'h1111_000C, A4 = 32'h2008_0001, A5 = 32'h2008_0002;
    localparam logic [31:0] A6 = 32'hABCD_0006, A7 = 32'hABCD_0007, A8 = 32'hABCD_0008;
    localparam logic [31:0] A9 = 32'hABCD_0009, I5 = 32'h2402_0005, JK = 32'hDEAD_BEEF;
    localparam logic [31:0] RB = 32'h0040_0100, B0 = 32'h3C01_1234;

    task automatic add(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic rspv, input logic [31:0] rdata, input logic qv,
                       input logic [31:0] qa, input logic iv, input logic [31:0] ii,
                       input logic [31:0] ip, input logic [31:0] ip4);
        vec_t v;
        v = '{st, rv, rpc, rdy, rspv, rdata, qv, qa, iv, ii, ip, ip4};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic qv, input logic [31:0] qa, input logic iv,
                           input logic [31:0] ii, input logic [31:0] ip, input logic [31:0] ip4);
        chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, qv});
        chk({tag, ".req_addr"}, imem_req_addr, qa);
        chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, iv});
        chk({tag, ".if_instr"}, if_instr, ii);
        chk({tag, ".if_pc"}, if_pc, ip);
        chk({tag, ".if_pc_plus4"}, if_pc_plus4, ip4);
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy,
                         input logic rspv, input logic [31:0] rdata);
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        imem_rsp_valid = rspv;
        imem_rsp_data  = rdata;
    endtask

    initial begin
        // sequential fetch 0x0, 0x4, 0x8 with 1-cycle latency
        add(0,0,0,1,0,0,  1,32'h0,0,0,0,0);
        add(0,0,0,1,1,A0, 0,32'h0,0,0,0,0);
        add(0,0,0,1,0,0,  1,32'h4,1,A0,32'h0,32'h4);
        add(0,0,0,1,1,A1, 0,32'h4,0,A0,32'h0,32'h4);
        add(0,0,0,1,0,0,  1,32'h8,1,A1,32'h4,32'h8);
        add(0,0,0,1,1,A2, 0,32'h8,0,A1,32'h4,32'h8);
        // ready low three cycles, accept on the fourth, 2-cycle latency
        add(0,0,0,0,0,0,  1,32'hC,1,A2,32'h8,32'hC);
        add(0,0,0,0,0,0,  1,32'hC,0,A2,32'h8,32'hC);
        add(0,0,0,0,0,0,  1,32'hC,0,A2,32'h8,32'hC);
        add(0,0,0,1,0,0,  1,32'hC,0,A2,32'h8,32'hC);
        add(0,0,0,1,0,0,  0,32'hC,0,A2,32'h8,32'hC);
        add(0,0,0,1,1,A3, 0,32'hC,0,A2,32'h8,32'hC);
        // response lands in skid under stall, drains on release
        add(1,0,0,1,0,0,  1,32'h10,1,A3,32'hC,32'h10);
        add(1,0,0,1,1,I5, 0,32'h10,1,A3,32'hC,32'h10);
        add(1,0,0,1,0,0,  0,32'h14,1,A3,32'hC,32'h10);
        add(0,0,0,1,0,0,  0,32'h14,1,A3,32'hC,32'h10);
        add(0,0,0,1,0,0,  1,32'h14,1,I5,32'h10,32'h14);
        // redirect while waiting: in-flight response dropped
        add(0,1,RB,0,0,0, 0,32'h14,0,I5,32'h10,32'h14);
        add(0,0,0,1,1,JK, 0,32'h14,0,I5,32'h10,32'h14);
        add(0,0,0,1,0,0,  1,RB,0,I5,32'h10,32'h14);
        add(0,0,0,1,1,A4, 0,RB,0,I5,32'h10,32'h14);
        // redirect (low bits set) together with stall in S_HOLD
        add(1,0,0,1,0,0,  1,32'h0040_0104,1,A4,RB,32'h0040_0104);
        add(1,0,0,1,1,A5, 0,32'h0040_0104,1,A4,RB,32'h0040_0104);
        add(1,1,32'h0040_0103,1,0,0, 0,32'h0040_0108,1,A4,RB,32'h0040_0104);
        add(1,0,0,0,0,0,  1,RB,0,A4,RB,32'h0040_0104);
        add(0,0,0,1,0,0,  1,RB,0,A4,RB,32'h0040_0104);
        // redirect to the top word: address wrap
        add(0,1,32'hFFFF_FFFC,0,0,0, 0,RB,0,A4,RB,32'h0040_0104);
        add(0,0,0,0,1,JK, 0,RB,0,A4,RB,32'h0040_0104);
        add(0,0,0,1,0,0,  1,32'hFFFF_FFFC,0,A4,RB,32'h0040_0104);
        add(0,0,0,1,1,A6, 0,32'hFFFF_FFFC,0,A4,RB,32'h0040_0104);
        add(0,0,0,0,0,0,  1,32'h0,1,A6,32'hFFFF_FFFC,32'h0);
        // redirect in the same cycle as the response: no kill left behind
        add(0,0,0,1,0,0,  1,32'h0,0,A6,32'hFFFF_FFFC,32'h0);
        add(0,1,32'h200,0,1,A7, 0,32'h0,0,A6,32'hFFFF_FFFC,32'h0);
        add(0,0,0,1,0,0,  1,32'h200,0,A6,32'hFFFF_FFFC,32'h0);
        add(0,0,0,0,1,A8, 0,32'h200,0,A6,32'hFFFF_FFFC,32'h0);
        add(0,0,0,0,0,0,  1,32'h204,1,A8,32'h200,32'h204);
        // redirect against an unaccepted request: it completes and is killed
        add(0,1,32'h300,0,0,0, 1,32'h204,0,A8,32'h200,32'h204);
        add(0,0,0,1,0,0,  1,32'h204,0,A8,32'h200,32'h204);
        add(0,0,0,0,1,JK, 0,32'h204,0,A8,32'h200,32'h204);
        add(0,0,0,1,0,0,  1,32'h300,0,A8,32'h200,32'h204);
        add(0,0,0,0,1,A9, 0,32'h300,0,A8,32'h200,32'h204);
        add(0,0,0,0,0,0,  1,32'h304,1,A9,32'h300,32'h304);

        rst_n = 1'b0;
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 0, 32'h0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].rspv, vecs[i].rdata);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].qv, vecs[i].qa, vecs[i].iv,
                    vecs[i].ii, vecs[i].ip, vecs[i].ip4);
            @(negedge clk);
        end

        // reset asserted while a request is in flight
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        chk("midrst.pre_req_valid", {31'd0, imem_req_valid}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_all("midrst.asserted", 0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, JK);
        #1;
        chk_all("midrst.release", 1, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0);
        #1;
        chk_all("midrst.stray", 1, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, B0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_all("midrst.first", 1, 32'h4, 1, B0, 32'h0, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
